// File: rtl/i2c_byte_ctrl.sv
// rtl/i2c_byte_ctrl.sv - byte-level I2C master sequencer
// Splits one START/WRITE|READ/STOP command into bit-controller requests.
module i2c_byte_ctrl #(
    parameter int TO_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_ack,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       ack_out,
    output logic       done,
    output logic       err,
    output logic       bit_en,
    output logic       bit_rw,
    output logic       bit_w,
    output logic       bit_start,
    output logic       bit_stop,
    input  logic       bit_busy,
    input  logic       bit_r
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WR_BIT, S_WR_ACK, S_RD_BIT, S_RD_ACK, S_STOP, S_DONE
    } state_t;
    typedef enum logic [1:0] {P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_t;

    // Timeout is flagged one count early so done lands 2^TO_W-1 cycles into the wait.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] TO_ONE  = 1;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d, dout_q, dout_d;
    logic            start_q, start_d, stop_q, stop_d, wr_q, wr_d, rd_q, rd_d, ack_q, ack_d;
    logic            ack_out_q, ack_out_d, done_q, done_d, err_q, err_d, init_q, init_d;
    logic            bit_en_q, bit_en_d, bit_rw_q, bit_rw_d, bit_w_q, bit_w_d;
    logic            bit_start_q, bit_start_d, bit_stop_q, bit_stop_d;
    logic            bit_done, timeout;

    function automatic state_t data_phase(input logic wr, input logic rd, input logic stop);
        if (wr)        data_phase = S_WR_BIT;
        else if (rd)   data_phase = S_RD_BIT;
        else if (stop) data_phase = S_STOP;
        else           data_phase = S_DONE;
    endfunction

    assign cmd_ready = init_q && (state_q == S_IDLE);
    assign dout      = dout_q;
    assign ack_out   = ack_out_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bit_en    = bit_en_q;
    assign bit_rw    = bit_rw_q;
    assign bit_w     = bit_w_q;
    assign bit_start = bit_start_q;
    assign bit_stop  = bit_stop_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        start_d     = start_q;
        stop_d      = stop_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        ack_d       = ack_q;
        ack_out_d   = ack_out_q;
        err_d       = 1'b0;
        init_d      = 1'b1;
        bit_en_d    = 1'b0;
        bit_rw_d    = bit_rw_q;
        bit_w_d     = bit_w_q;
        bit_start_d = bit_start_q;
        bit_stop_d  = bit_stop_q;
        bit_done    = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    start_d  = cmd_start;
                    stop_d   = cmd_stop;
                    wr_d     = cmd_write;
                    rd_d     = cmd_read & ~cmd_write;
                    ack_d    = cmd_ack;
                    shift_d  = din;
                    bitcnt_d = 3'd7;
                    phase_d  = P_ISSUE;
                    state_d  = cmd_start ? S_START
                                         : data_phase(cmd_write, cmd_read & ~cmd_write, cmd_stop);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                case (phase_q)
                    P_ISSUE: begin
                        bit_en_d    = 1'b1;
                        bit_start_d = (state_q == S_START);
                        bit_stop_d  = (state_q == S_STOP);
                        bit_rw_d    = (state_q == S_WR_BIT) || (state_q == S_RD_ACK);
                        bit_w_d     = (state_q == S_WR_BIT) ? shift_q[7] :
                                      (state_q == S_RD_ACK) ? ack_q : 1'b0;
                        cnt_d       = '0;
                        phase_d     = P_WAIT_HI;
                    end
                    P_WAIT_HI: begin
                        if (bit_busy)               phase_d = P_WAIT_LO;
                        else if (cnt_q == TO_LAST)  timeout = 1'b1;
                        cnt_d = cnt_q + TO_ONE;
                    end
                    P_WAIT_LO: begin
                        if (!bit_busy)              bit_done = 1'b1;
                        else if (cnt_q == TO_LAST)  timeout = 1'b1;
                        cnt_d = cnt_q + TO_ONE;
                    end
                    default: phase_d = P_ISSUE;
                endcase
            end
        endcase

        if (timeout) begin
            state_d = S_DONE;
            phase_d = P_ISSUE;
            err_d   = 1'b1;
        end else if (bit_done) begin
            phase_d = P_ISSUE;
            case (state_q)
                S_START: state_d = data_phase(wr_q, rd_q, stop_q);
                S_WR_BIT: begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bitcnt_q == 3'd0) state_d = S_WR_ACK;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end
                S_WR_ACK: begin
                    ack_out_d = bit_r;
                    state_d   = stop_q ? S_STOP : S_DONE;
                end
                S_RD_BIT: begin
                    shift_d = {shift_q[6:0], bit_r};
                    if (bitcnt_q == 3'd0) state_d = S_RD_ACK;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end
                S_RD_ACK: state_d = stop_q ? S_STOP : S_DONE;
                S_STOP:   state_d = S_DONE;
                default:  state_d = S_DONE;
            endcase
        end

        // Only a fully completed read command publishes its byte.
        if (state_d == S_DONE && state_q != S_IDLE && !timeout && rd_q)
            dout_d = shift_q;
        if (state_d == S_DONE) begin
            bit_start_d = 1'b0;
            bit_stop_d  = 1'b0;
            bit_rw_d    = 1'b0;
            bit_w_d     = 1'b0;
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            phase_q     <= P_ISSUE;
            cnt_q       <= '0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            dout_q      <= 8'h00;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            ack_q       <= 1'b0;
            ack_out_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            init_q      <= 1'b0;
            bit_en_q    <= 1'b0;
            bit_rw_q    <= 1'b0;
            bit_w_q     <= 1'b0;
            bit_start_q <= 1'b0;
            bit_stop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ack_q       <= ack_d;
            ack_out_q   <= ack_out_d;
            done_q      <= done_d;
            err_q       <= err_d;
            init_q      <= init_d;
            bit_en_q    <= bit_en_d;
            bit_rw_q    <= bit_rw_d;
            bit_w_q     <= bit_w_d;
            bit_start_q <= bit_start_d;
            bit_stop_q  <= bit_stop_d;
        end
    end

endmodule

// File: doc/i2c_byte_ctrl.md
# i2c_byte_ctrl

Byte-level I2C master sequencer sitting directly upstream of the bit-level bus controller. It accepts one command (optional START, write-byte or read-byte, optional STOP) per handshake and decomposes it into single-bit requests (start, stop, write bit, read bit) issued over the bit controller's `en`/`busy` interface. It returns the received byte and the slave ACK, and aborts with an error if the bit controller stalls.

## Interface
Parameters:
- `TO_W`, 16: width of the bit-stall timeout counter; timeout fires after 2^TO_W−1 cycles waiting on one bit.

Ports:
- `clk` in 1: system clock (same clock as the bit controller).
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_start` in 1: generate START before the data phase.
- `cmd_stop` in 1: generate STOP after the data phase.
- `cmd_write` in 1: write `din` (priority over `cmd_read`).
- `cmd_read` in 1: read one byte into `dout`.
- `cmd_ack` in 1: ACK level driven after a read (0 = ACK, 1 = NACK).
- `din` in 8: write data, MSB first.
- `dout` out 8: last read byte.
- `ack_out` out 1: ACK bit sampled from slave after the last write (0 = ACK).
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: one-cycle pulse, coincident with `done`, on timeout.
- `bit_en`, `bit_rw`, `bit_w`, `bit_start`, `bit_stop` out 1 each: request to bit controller (`bit_rw` 1 = write, 0 = read).
- `bit_busy` in 1, `bit_r` in 1: bit controller status and read bit.

## Operation
- Reset values: `cmd_ready`=0 until the first post-reset cycle, then 1; `dout`=0x00, `ack_out`=1, `done`=0, `err`=0, all `bit_*` outputs 0; state IDLE, shift register 0, counter 0.
- Accept: latch `din`, `cmd_*` flags into internal registers; `cmd_ready` drops the next cycle.
- Phase order: START (if set) → WRITE (8 bits + ACK read) or READ (8 bits + ACK write) → STOP (if set) → DONE. Phases not requested are skipped; a command with no flags set goes straight to DONE.
- States: IDLE, START, WR_BIT, WR_ACK, RD_BIT, RD_ACK, STOP, DONE. Each bit state runs three sub-phases:
  - ISSUE: `bit_en`=1 for exactly one cycle with `bit_start`/`bit_stop`/`bit_rw`/`bit_w` valid; these stay stable through the whole bit.
  - WAIT_HI: wait for `bit_busy`=1.
  - WAIT_LO: wait for `bit_busy`=0, then advance.
- WR_BIT: `bit_rw`=1, `bit_w`=shift[7]; shift left after each bit; 3-bit counter 7→0; after bit 0 → WR_ACK.
- WR_ACK: `bit_rw`=0; on completion `ack_out`←`bit_r`.
- RD_BIT: `bit_rw`=0; on completion shift ← {shift[6:0], `bit_r`}; after 8 bits → RD_ACK.
- RD_ACK: `bit_rw`=1, `bit_w`=`cmd_ack`; `dout` updates from shift on entry to DONE.
- A NACK on write does not abort; STOP still runs if requested.
- Timeout: counter clears at each ISSUE and counts in WAIT_HI/WAIT_LO. At terminal count → DONE with `err`=1; `bit_en` stays 0; `dout`/`ack_out` are not updated.
- Reset mid-command: asynchronous return to reset values; no `done` pulse is generated. The bit controller is reset separately.

## Timing
- `bit_en` asserts the cycle after entry to a bit state.
- The bit controller needs ≥4 frame periods per bit; byte-controller overhead is ≤3 `clk` cycles per bit.
- `done` is asserted the cycle after the final WAIT_LO exit. `cmd_ready` returns high the cycle after `done`.
- `cmd_valid` while `cmd_ready`=0 is ignored and not queued.
- `dout` and `ack_out` hold until overwritten by the next successful read or write.

## Test plan
- START+WRITE 0xA5+STOP, slave ACKs: `bit_w` sequence is 1,0,1,0,0,1,0,1. Expected: 11 `bit_en` pulses (start, 8 bits, ack read, stop); `ack_out`=0; one `done`; `err`=0.
- READ with `cmd_ack`=1, slave drives 0x3C. Expected: `dout`=0x3C at `done`; ACK bit issued with `bit_rw`=1, `bit_w`=1.
- WRITE 0x00 with slave NACK (`bit_r`=1) plus STOP. Expected: `ack_out`=1; STOP still issued; `done` pulse; `err`=0.
- `bit_busy` held low forever after ISSUE, `TO_W`=4. Expected: `done` and `err` pulse together 15 cycles after the wait starts; `dout` unchanged.
- `rst` asserted during bit 4 of a write. Expected: immediate `bit_en`=0, no `done`; a fresh command after release completes normally.
- Command with all flags 0. Expected: zero `bit_en` pulses; `done` within 2 cycles of accept.
